// File: rtl/logic_unit_pkg.sv
// Shared constants for the bitwise logic unit: truth-table encodings and reset table.
// A truth table is indexed by {a, b}, so bit 3 is the a=1,b=1 result.
package logic_unit_pkg;

  localparam logic [3:0] FUNC_OR   = 4'b1110;
  localparam logic [3:0] FUNC_XOR  = 4'b0110;
  localparam logic [3:0] FUNC_AND  = 4'b1000;
  localparam logic [3:0] FUNC_NAND = 4'b0111;
  localparam logic [3:0] FUNC_ZERO = 4'b0000;

  function automatic logic [3:0] reset_func(input int idx);
    case (idx)
      0:       return FUNC_OR;
      1:       return FUNC_XOR;
      2:       return FUNC_AND;
      default: return FUNC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// Single valid/ready register slice with full throughput.
// It accepts a new beat whenever it is empty or its current beat leaves this cycle.
module logic_unit_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Data holds while stalled; a bubble clears valid but leaves stale data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage elastic bitwise logic unit with a programmable truth-table file.
// S1 captures operands plus the selected truth table; S2 registers the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_addr,
  input  logic [3:0]       cfg_func,
  input  logic             clr_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err,
  output logic [15:0]      op_count
);

  localparam int S1_W = 2 * WIDTH + 5;
  localparam int S2_W = WIDTH + 2;

  logic [3:0]       func_tbl [DEPTH];
  logic             sel_ok;
  logic [3:0]       sel_func;
  logic             s1_in_ready;
  logic             s1_valid;
  logic             s2_in_ready;
  logic [S1_W-1:0]  s1_in;
  logic [S1_W-1:0]  s1_out;
  logic             s1_err;
  logic [3:0]       s1_func;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] result;
  logic [S2_W-1:0]  s2_in;
  logic [S2_W-1:0]  s2_out;

  // Captured into S1 at acceptance, so a same-edge table write only affects later beats.
  always_comb begin
    sel_ok   = (int'(in_sel) < DEPTH);
    sel_func = FUNC_ZERO;
    if (sel_ok) sel_func = func_tbl[in_sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) func_tbl[i] <= reset_func(i);
    end else if (cfg_we && (int'(cfg_addr) < DEPTH)) begin
      func_tbl[cfg_addr] <= cfg_func;
    end
  end

  assign s1_in    = {!sel_ok, sel_func, in_a, in_b};
  assign in_ready = rst_n && s1_in_ready;

  logic_unit_stage #(.WIDTH(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_out)
  );

  always_comb begin
    {s1_err, s1_func, s1_a, s1_b} = s1_out;
    result = '0;
    for (int i = 0; i < WIDTH; i++) result[i] = s1_func[{s1_a[i], s1_b[i]}];
  end

  assign s2_in = {s1_err, ~|result, result};

  logic_unit_stage #(.WIDTH(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign {out_err, out_zero, out_data} = s2_out;

  // Clear wins over a simultaneous handshake; otherwise count up and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (clr_cnt) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed steps plus random traffic against a queue model.
// A DEPTH=3 copy shares all inputs so out-of-range selects and ignored writes can be observed.
module tb_logic_unit_pipe;

  localparam int W = 8;

  typedef struct packed {
    logic         err;
    logic         zero;
    logic [W-1:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = '0;
  logic [3:0]   cfg_func = '0;
  logic         clr_cnt = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   in_sel = '0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_valid, out_zero, out_err;
  logic [W-1:0] out_data;
  logic [15:0]  op_count;
  logic         in_ready3, out_valid3, out_zero3, out_err3;
  logic [W-1:0] out_data3;
  logic [15:0]  op_count3;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_func(cfg_func),
    .clr_cnt(clr_cnt), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_err(out_err), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(W), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_func(cfg_func),
    .clr_cnt(clr_cnt), .in_valid(in_valid), .in_ready(in_ready3), .in_a(in_a), .in_b(in_b),
    .in_sel(in_sel), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_zero(out_zero3), .out_err(out_err3), .op_count(op_count3)
  );

  beat_t      q4[$];
  beat_t      q3[$];
  logic [3:0] tab4 [4];
  logic [3:0] tab3 [4];
  int         exp_count = 0;
  logic       stalled = 1'b0;
  int         checks = 0;
  int         passes = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic beat_t ref_beat(input logic [3:0] f, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic err);
    beat_t r;
    r.data = '0;
    for (int i = 0; i < W; i++) r.data[i] = f[int'(a[i]) * 2 + int'(b[i])];
    r.zero = (r.data == '0);
    r.err  = err;
    return r;
  endfunction

  task automatic modelReset();
    tab4 = '{4'b1110, 4'b0110, 4'b1000, 4'b0000};
    tab3 = '{4'b1110, 4'b0110, 4'b1000, 4'b0000};
    q4.delete();
    q3.delete();
    exp_count = 0;
    stalled = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, score outputs, update the model, advance.
  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] sel, input logic oready, input logic we,
                               input logic [1:0] waddr, input logic [3:0] wfunc,
                               input logic clr, output logic acc);
    int  occ;
    logic hs;
    in_valid = v; in_a = a; in_b = b; in_sel = sel; out_ready = oready;
    cfg_we = we; cfg_addr = waddr; cfg_func = wfunc; clr_cnt = clr;
    #1;
    acc = 1'b0;
    occ = q4.size();
    checkOutput("op_count", 64'(op_count), 64'(exp_count));
    checkOutput("in_ready", 64'(in_ready), 64'((occ < 2) || oready));
    checkOutput("in_ready3", 64'(in_ready3), 64'((occ < 2) || oready));
    if (stalled) checkOutput("stall_hold_valid", 64'(out_valid), 64'd1);
    if (occ == 0) begin
      checkOutput("spurious_beat", 64'(out_valid), 64'd0);
      checkOutput("spurious_beat3", 64'(out_valid3), 64'd0);
    end else if (out_valid) begin
      checkOutput("data", 64'({out_err, out_zero, out_data}), 64'(q4[0]));
      checkOutput("data3", 64'({out_err3, out_zero3, out_data3}), 64'(q3[0]));
    end
    hs = out_valid && oready;
    if (hs && occ > 0) begin
      void'(q4.pop_front());
      void'(q3.pop_front());
    end
    stalled = out_valid && !oready;
    if (v && in_ready) begin
      acc = 1'b1;
      q4.push_back(ref_beat(tab4[sel], a, b, 1'b0));
      if (sel < 2'd3) q3.push_back(ref_beat(tab3[sel], a, b, 1'b0));
      else            q3.push_back(ref_beat(4'b0000, a, b, 1'b1));
    end
    if (we) begin
      tab4[waddr] = wfunc;
      if (waddr < 2'd3) tab3[waddr] = wfunc;
    end
    if (clr) exp_count = 0;
    else if (hs && exp_count < 65535) exp_count++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic oready);
    logic acc;
    applyStimulus(1'b0, '0, '0, 2'd0, oready, 1'b0, 2'd0, 4'd0, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q4.size() > 0; i++) idle(1'b1);
    checkOutput("drain_empty", 64'(q4.size()), 64'd0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_outputs", 64'({out_data, out_zero, out_err}), 64'd0);
    checkOutput("rst_op_count", 64'(op_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    logic       acc;
    logic [W-1:0] ra, rb;
    logic [1:0] rs;
    int         sent, guard;
    logic       saw_not_ready;

    modelReset();
    @(negedge clk);
    resetDut();

    // Reset-default tables with a 2-cycle latency
    applyStimulus(1'b1, 8'hF0, 8'hCC, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, acc);
    checkOutput("lat_not_yet", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 8'hF0, 8'hCC, 2'd1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, acc);
    checkOutput("lat_or", 64'({out_valid, out_data}), 64'({1'b1, 8'hFC}));
    applyStimulus(1'b1, 8'hF0, 8'hCC, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, acc);
    checkOutput("lat_xor", 64'({out_valid, out_data}), 64'({1'b1, 8'h3C}));
    idle(1'b1);
    checkOutput("lat_and", 64'({out_valid, out_data}), 64'({1'b1, 8'hC0}));
    drain();

    // Reprogram entry 3, then a write and acceptance on the same edge
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b1, 2'd3, 4'b0111, 1'b0, acc);
    applyStimulus(1'b1, 8'hFF, 8'h0F, 2'd3, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, acc);
    applyStimulus(1'b1, 8'hFF, 8'h0F, 2'd3, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, acc);
    checkOutput("nand", 64'(out_data), 64'(8'hF0));
    checkOutput("err3", 64'({out_err3, out_zero3, out_data3}), 64'({1'b1, 1'b1, 8'h00}));
    applyStimulus(1'b1, 8'hFF, 8'h0F, 2'd3, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, acc);
    checkOutput("same_cycle_old", 64'(out_data), 64'(8'hF0));
    idle(1'b1);
    checkOutput("new_value", 64'(out_data), 64'(8'h0F));
    checkOutput("ignored_write3", 64'({out_err3, out_zero3, out_data3}), 64'({1'b1, 1'b1, 8'h00}));
    drain();

    // Ten back-to-back beats against a 1,0,0,1 ready pattern
    sent = 0;
    guard = 0;
    saw_not_ready = 1'b0;
    while (sent < 10 && guard < 100) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 2'($urandom);
      applyStimulus(1'b1, ra, rb, rs, ((guard % 4) == 0) || ((guard % 4) == 3),
                    1'b0, 2'd0, 4'd0, 1'b0, acc);
      if (acc) sent++;
      else saw_not_ready = 1'b1;
      guard++;
    end
    checkOutput("bp_all_sent", 64'(sent), 64'd10);
    checkOutput("bp_ready_dropped", 64'(saw_not_ready), 64'd1);
    drain();

    // Random traffic with table writes and occasional counter clears
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 2'($urandom);
      applyStimulus(1'($urandom), ra, rb, rs, ($urandom_range(3) != 0),
                    ($urandom_range(5) == 0), 2'($urandom), 4'($urandom),
                    ($urandom_range(40) == 0), acc);
    end
    drain();

    // Saturating counter, then a clear that coincides with a handshake
    idle(1'b1);
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1, acc);
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1,
                    1'b0, 2'd0, 4'd0, 1'b0, acc);
    end
    checkOutput("count_sat", 64'(op_count), 64'(16'hFFFF));
    checkOutput("hs_before_clr", 64'(out_valid), 64'd1);
    applyStimulus(1'b1, 8'h55, 8'hAA, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1, acc);
    checkOutput("clr_with_hs", 64'(op_count), 64'd0);
    drain();

    // Reset with two beats in flight: nothing may survive, tables return to defaults
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, acc);
    applyStimulus(1'b1, 8'h12, 8'h34, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, acc);
    applyStimulus(1'b1, 8'h56, 8'h78, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, acc);
    checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    resetDut();
    for (int i = 0; i < 4; i++) idle(1'b1);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'(s), 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, acc);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
